// File: rtl/apb_pkg.sv
// apb_pkg: shared APB bus definitions for the completer.
//  - Bus widths, memory geometry and FSM state encoding.
//  - Captured-transfer payload struct.
//  - Protection-region helpers and the transfer error decode.
package apb_pkg;

   localparam int unsigned ADDR_WIDTH = 16;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned ALIGNBITS  = $clog2(STRB_WIDTH);
   localparam int unsigned MEM_WORDS  = 256;
   localparam int unsigned IDX_W      = $clog2(MEM_WORDS);
   localparam int unsigned WAIT_W     = 4;

   localparam logic [2:0] PPROT_LOW  = 3'b000;
   localparam logic [2:0] PPROT_HIGH = 3'b111;

   // SETUP is reserved: the setup phase is sampled from IDLE directly.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } state_t;

   // Transfer fields latched at the setup edge.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic                  write;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_WIDTH-1:0] strb;
      logic                  err;
   } xfer_t;

   // The address MSB selects the region; each region demands one PPROT value.
   function automatic logic [2:0] getPprot(input logic [ADDR_WIDTH-1:0] addr);
      return addr[ADDR_WIDTH-1] ? PPROT_HIGH : PPROT_LOW;
   endfunction

   // Base address of the region that accepts the given PPROT value.
   function automatic logic [ADDR_WIDTH-1:0] getAddrforPprot(input logic [2:0] pprot);
      return (pprot == PPROT_HIGH) ? (ADDR_WIDTH'(1) << (ADDR_WIDTH - 1)) : '0;
   endfunction

   // Bits between the word index and the region bit must be zero.
   function automatic logic inRange(input logic [ADDR_WIDTH-1:0] addr);
      return addr[ADDR_WIDTH-2 : ALIGNBITS+IDX_W] == '0;
   endfunction

   // Returns {misaligned, out_of_range, prot_bad}.
   function automatic logic [2:0] errCheck(input logic [ADDR_WIDTH-1:0] addr,
                                           input logic [2:0]            pprot);
      logic [2:0] r;
      r[2] = addr[ALIGNBITS-1:0] != '0;
      r[1] = !inRange(addr);
      r[0] = pprot != getPprot(addr);
      return r;
   endfunction

endpackage

// File: rtl/apb_completer_mem.sv
// apb_completer_mem: word array with byte-enable synchronous write and
// combinational read. Contents are not reset.
//  clk    in  clock
//  we     in  write enable
//  waddr  in  write word index
//  wdata  in  write data
//  wstrb  in  byte lane enables
//  raddr  in  read word index
//  rdata  out read data (combinational)
module apb_completer_mem #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_W      = 9
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [IDX_W-1:0]        waddr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic [IDX_W-1:0]        raddr,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int unsigned DEPTH  = 1 << IDX_W;
   localparam int unsigned NBYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Byte-lane write.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int n = 0; n < int'(NBYTES); n++) begin
            if (wstrb[n]) begin
               mem_q[waddr][8*n +: 8] <= wdata[8*n +: 8];
            end
         end
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_completer.sv
// apb_completer: APB4 completer in front of a two-region byte-strobed word memory.
//  - Consumes one transfer at a time and inserts WAIT_STATES wait cycles.
//  - Misaligned, out-of-range and PPROT-mismatched transfers get PSLVERR.
//  - Widths follow apb_pkg.
//  PCLK/PRESETn             clock, async active-low reset
//  PSEL/PENABLE/PWRITE      APB control
//  PADDR/PWDATA/PSTRB/PPROT APB request payload
//  PREADY/PRDATA/PSLVERR    registered APB response
module apb_completer #(
   parameter int unsigned ADDR_WIDTH  = apb_pkg::ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = apb_pkg::DATA_WIDTH,
   parameter int unsigned MEM_WORDS   = apb_pkg::MEM_WORDS,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [2:0]              PPROT,
   output logic                    PREADY,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PSLVERR
);

   import apb_pkg::*;

   localparam int unsigned MIDX_W = $clog2(MEM_WORDS);
   localparam int unsigned MEM_IW = MIDX_W + 1;
   localparam int unsigned AL     = $clog2(DATA_WIDTH / 8);

   state_t                 state_q, state_d;
   logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
   xfer_t                  cap_q, cap_d;
   logic                   pready_q, pready_d;
   logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;
   logic                   pslverr_q, pslverr_d;

   logic                   setup_c;
   logic                   start_c;
   logic                   violation_c;
   logic                   done_c;
   logic [2:0]             err_vec_c;
   logic [MEM_IW-1:0]      req_idx_c;
   logic [MEM_IW-1:0]      cap_idx_c;
   logic [MEM_IW-1:0]      rd_idx_c;
   logic [DATA_WIDTH-1:0]  rd_word_c;
   logic                   mem_we_c;

   assign setup_c   = PSEL && !PENABLE;
   assign start_c   = (state_q == IDLE) && setup_c;
   assign err_vec_c = errCheck(PADDR, PPROT);

   // Region bit on top keeps the two regions from aliasing.
   assign req_idx_c = {PADDR[ADDR_WIDTH-1], PADDR[AL +: MIDX_W]};
   assign cap_idx_c = {cap_q.addr[ADDR_WIDTH-1], cap_q.addr[AL +: MIDX_W]};

   // Read port follows the transfer that will be in ACCESS next cycle.
   assign rd_idx_c  = start_c ? req_idx_c : cap_idx_c;

   // Requester must hold the access phase stable while PREADY is low.
   assign violation_c = !PSEL || !PENABLE ||
                        (PADDR != cap_q.addr) || (PWRITE != cap_q.write);

   // Write commits on the completion edge only.
   assign mem_we_c = (state_q == ACCESS) && (wait_cnt_q == '0) &&
                     cap_q.write && !cap_q.err;

   apb_completer_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (MEM_IW)
   ) u_mem (
      .clk   (PCLK),
      .we    (mem_we_c),
      .waddr (cap_idx_c),
      .wdata (cap_q.wdata),
      .wstrb (cap_q.strb),
      .raddr (rd_idx_c),
      .rdata (rd_word_c)
   );

   // Next-state and next-output decode.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      cap_d      = cap_q;
      done_c     = 1'b0;
      pready_d   = 1'b0;
      prdata_d   = '0;
      pslverr_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (setup_c) begin
               state_d     = ACCESS;
               wait_cnt_d  = WAIT_W'(WAIT_STATES);
               cap_d.addr  = PADDR;
               cap_d.write = PWRITE;
               cap_d.wdata = PWDATA;
               cap_d.strb  = PSTRB;
               cap_d.err   = |err_vec_c;
            end
         end
         ACCESS: begin
            if (wait_cnt_q == '0) begin
               state_d = IDLE;
            end else if (violation_c) begin
               state_d = ERROR;
            end else begin
               wait_cnt_d = wait_cnt_q - WAIT_W'(1);
            end
         end
         ERROR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // PREADY is a Moore function of the next state and counter.
      done_c    = (state_d == ACCESS) && (wait_cnt_d == '0);
      pready_d  = done_c;
      pslverr_d = done_c && cap_d.err;
      if (done_c && !cap_d.write && !cap_d.err) begin
         prdata_d = rd_word_c;
      end
   end

   // State and output registers.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         cap_q      <= '0;
         pready_q   <= 1'b0;
         prdata_q   <= '0;
         pslverr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         cap_q      <= cap_d;
         pready_q   <= pready_d;
         prdata_q   <= prdata_d;
         pslverr_q  <= pslverr_d;
      end
   end

   assign PREADY  = pready_q;
   assign PRDATA  = prdata_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_completer.sv
// Scoreboard bench for apb_completer: two instances (0 and 3 wait states)
// share one driven bus; a reference memory model predicts each response.
module tb_apb_completer;

   logic        clk;
   logic        presetn;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   int          dut_sel;

   logic        psel0, psel3;
   logic        pready0, pready3, pslverr0, pslverr3;
   logic [31:0] prdata0, prdata3;
   logic        pready_m, pslverr_m;
   logic [31:0] prdata_m;

   assign psel0     = psel && (dut_sel == 0);
   assign psel3     = psel && (dut_sel == 1);
   assign pready_m  = (dut_sel == 0) ? pready0  : pready3;
   assign pslverr_m = (dut_sel == 0) ? pslverr0 : pslverr3;
   assign prdata_m  = (dut_sel == 0) ? prdata0  : prdata3;

   apb_completer #(.WAIT_STATES(0)) dut0 (
      .PCLK(clk), .PRESETn(presetn), .PSEL(psel0), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PPROT(pprot), .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0)
   );

   apb_completer #(.WAIT_STATES(3)) dut3 (
      .PCLK(clk), .PRESETn(presetn), .PSEL(psel3), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PPROT(pprot), .PREADY(pready3), .PRDATA(prdata3), .PSLVERR(pslverr3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_mem [2][512];
   int unsigned n_cmp;
   int unsigned n_bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference rules: 4-byte words, bits 14:10 must be zero, region 1 needs PPROT=7.
   function automatic logic model_err(input logic [15:0] a, input logic [2:0] p);
      int ai;
      int need;
      ai   = int'(a);
      need = (ai >= 32768) ? 7 : 0;
      return ((ai % 4) != 0) || (((ai % 32768) / 1024) != 0) || (int'(p) != need);
   endfunction

   function automatic int model_key(input logic [15:0] a);
      int ai;
      ai = int'(a);
      return ((ai >= 32768) ? 256 : 0) + ((ai % 1024) / 4);
   endfunction

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   // Monitor: every PREADY cycle consumes one expected response.
   always @(negedge clk) begin
      exp_t e;
      if (presetn && pready_m) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pready: got PREADY=1 expected no response (t=%0t)", $time);
         end else begin
            e = exp_q.pop_front();
            check("prdata", prdata_m, e.data);
            check("pslverr", 32'(pslverr_m), 32'(e.err));
         end
      end
   end

   // One full transfer; returns just after the completion edge with PSEL still high.
   task automatic xfer(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
      exp_t e;
      int   k;
      int   cycles;
      bit   got;
      e.err  = model_err(a, p);
      e.data = '0;
      k      = model_key(a);
      if (w && !e.err) begin
         for (int n = 0; n < 4; n++) begin
            if (s[n]) model_mem[dut_sel][k][8*n +: 8] = d[8*n +: 8];
         end
      end
      if (!w && !e.err) e.data = model_mem[dut_sel][k];
      exp_q.push_back(e);

      psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a;
      pwdata = d; pstrb = s; pprot = p;
      @(posedge clk); #1 penable = 1'b1;
      cycles = 0;
      got    = 1'b0;
      while (!got && cycles < 40) begin
         @(negedge clk);
         cycles++;
         if (pready_m) got = 1'b1;
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL pready_timeout: got no PREADY in %0d cycles expected %0d", cycles, 1 + ws_of(dut_sel));
      end else begin
         check("latency", 32'(cycles), 32'(1 + ws_of(dut_sel)));
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      psel = 1'b0; penable = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
      xfer(1'b1, a, d, s, p);
      idle(1);
   endtask

   task automatic rd(input logic [15:0] a, input logic [2:0] p);
      xfer(1'b0, a, 32'h0, 4'h0, p);
      idle(1);
   endtask

   // Watch for PREADY over n cycles with no expectation queued.
   task automatic expect_quiet(input string name, input int n);
      int seen;
      seen = 0;
      repeat (n) begin
         @(negedge clk);
         if (pready_m) seen++;
      end
      check(name, 32'(seen), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [15:0] a;
      logic [2:0]  p;
      int          rg;
      n_cmp = 0; n_bad = 0;
      dut_sel = 0;
      presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_pready0", 32'(pready0), 32'd0);
      check("reset_prdata0", prdata0, 32'd0);
      check("reset_pslverr0", 32'(pslverr0), 32'd0);
      check("reset_pready3", 32'(pready3), 32'd0);
      @(negedge clk) presetn = 1'b1;
      @(posedge clk); #1;

      // Known contents for both instances and both regions.
      for (int d = 0; d < 2; d++) begin
         dut_sel = d;
         for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 8; w++) begin
               a = 16'(r * 32768 + w * 4);
               wr(a, $urandom, 4'hF, (r == 1) ? 3'd7 : 3'd0);
            end
         end
      end

      // Directed, no wait states.
      dut_sel = 0;
      wr(16'h0010, 32'hDEADBEEF, 4'hF, 3'd0);
      rd(16'h0010, 3'd0);
      wr(16'h0010, 32'h11223344, 4'b0101, 3'd0);
      rd(16'h0010, 3'd0);
      check("strobe_model", model_mem[0][4], 32'hDE22BE44);
      wr(16'h0010, 32'hFFFFFFFF, 4'h0, 3'd0);
      rd(16'h0010, 3'd0);
      wr(16'h0012, 32'h0BADF00D, 4'hF, 3'd0);
      wr(16'h0400, 32'h0BADF00D, 4'hF, 3'd0);
      wr(16'h8010, 32'h0BADF00D, 4'hF, 3'd0);
      rd(16'h0010, 3'd0);
      wr(16'h8010, 32'hA5A5A5A5, 4'hF, 3'd7);
      rd(16'h8010, 3'd7);
      rd(16'h0010, 3'd0);

      // Access phase without a setup phase is ignored.
      psel = 1'b1; penable = 1'b1; paddr = 16'h0010; pwrite = 1'b0; pprot = 3'd0;
      expect_quiet("no_setup_pready", 4);
      idle(1);

      // Wait states, then back-to-back reads and writes.
      dut_sel = 1;
      rd(16'h0010, 3'd0);
      xfer(1'b1, 16'h0014, 32'hCAFEF00D, 4'hF, 3'd0);
      xfer(1'b0, 16'h0014, 32'h0, 4'h0, 3'd0);
      xfer(1'b0, 16'h0010, 32'h0, 4'h0, 3'd0);
      idle(1);

      // PSEL dropped mid-wait: ERROR then IDLE, write dropped.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0010;
      pwdata = 32'h55555555; pstrb = 4'hF; pprot = 3'd0;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
      expect_quiet("abort_pready", 6);
      rd(16'h0010, 3'd0);

      // Reset during ACCESS drops PREADY at once and blocks the write.
      dut_sel = 0;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0010;
      pwdata = 32'h77777777; pstrb = 4'hF; pprot = 3'd0;
      @(posedge clk); #1 presetn = 1'b0;
      #1;
      check("async_reset_pready", 32'(pready0), 32'd0);
      check("async_reset_prdata", prdata0, 32'd0);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk) presetn = 1'b1;
      @(posedge clk); #1;
      rd(16'h0010, 3'd0);
      dut_sel = 1;
      rd(16'h0010, 3'd0);

      // Randomized traffic on both instances.
      for (int d = 0; d < 2; d++) begin
         dut_sel = d;
         repeat (150) begin
            rg = int'($urandom_range(1));
            a  = 16'(rg * 32768 + int'($urandom_range(7)) * 4);
            p  = (rg == 1) ? 3'd7 : 3'd0;
            case ($urandom_range(7))
               0: a = a + 16'($urandom_range(3, 1));
               1: a = a | 16'(int'($urandom_range(31, 1)) << 10);
               2: p = p ^ 3'($urandom_range(7, 1));
               default: ;
            endcase
            xfer(1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)), p);
            if ($urandom_range(3) == 0) idle(1);
         end
         idle(2);
      end

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test expected completion before 2 ms");
      $fatal(1);
   end

endmodule
